// File: rtl/main_fsm_pkg.sv
// ---------------------------------------------------------------------------
// main_fsm_pkg
// Shared definitions for the multicycle rv32i control FSM:
//   - state_e       : FSM state enumeration (CSR only with MAIN_FSM_CSR_EN)
//   - OP_*          : opcode field values recognised by the decoder
//   - ADR_/ALUA_/ALUB_/ALUOP_/RES_ : datapath select encodings
//   - CAUSE_*       : trap cause codes reported on trap_cause
//   - decode_op()   : opcode -> post-DECODE state
//   - is_mem_wait() : states that wait on the memory handshake
// Optional feature macro: MAIN_FSM_CSR_EN (adds the CSR state).
// ---------------------------------------------------------------------------
package main_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BRANCH,
    ST_JALR,
    ST_JAL,
`ifdef MAIN_FSM_CSR_EN
    ST_CSR,
`endif
    ST_TRAP
  } state_e;

  // Opcode field values
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_ITYPE  = 7'd19;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_SYSTEM = 7'd115;

  // Address mux
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  // ALU A operand
  localparam logic [1:0] ALUA_PC    = 2'b00;
  localparam logic [1:0] ALUA_OLDPC = 2'b01;
  localparam logic [1:0] ALUA_RS1   = 2'b10;
  localparam logic [1:0] ALUA_ZERO  = 2'b11;

  // ALU B operand
  localparam logic [1:0] ALUB_RS2   = 2'b00;
  localparam logic [1:0] ALUB_IMM   = 2'b01;
  localparam logic [1:0] ALUB_FOUR  = 2'b10;

  // ALU mode handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_CSR       = 2'b11;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // State that follows DECODE for a given opcode; unknown opcodes trap.
  function automatic state_e decode_op(input logic [6:0] op);
    state_e nxt;
    nxt = ST_TRAP;
    case (op)
      OP_LOAD, OP_STORE:          nxt = ST_MEMADR;
      OP_RTYPE:                   nxt = ST_EXECR;
      OP_ITYPE, OP_LUI, OP_AUIPC: nxt = ST_EXECI;
      OP_BRANCH:                  nxt = ST_BRANCH;
      OP_JAL:                     nxt = ST_JAL;
      OP_JALR:                    nxt = ST_JALR;
`ifdef MAIN_FSM_CSR_EN
      OP_SYSTEM:                  nxt = ST_CSR;
`endif
      default:                    nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

  // States that sit on the mem_rdy handshake and are guarded by the watchdog.
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// ---------------------------------------------------------------------------
// main_fsm_if
// Control bundle between the main FSM and the rv32i datapath/memory.
//   master (FSM side)     : reads op_code, mem_rdy; drives every select,
//                           enable, mem_req, trap and trap_cause.
//   slave (datapath side) : the mirror image.
// Optional feature macro: MAIN_FSM_CSR_EN (csr_w is only ever high when set).
// ---------------------------------------------------------------------------
interface main_fsm_if;
  logic [6:0] op_code;
  logic       mem_rdy;
  logic       mem_req;
  logic       adr_s;
  logic [1:0] alu_a_s;
  logic [1:0] alu_b_s;
  logic [1:0] alu_op;
  logic [1:0] result_s;
  logic       ir_w;
  logic       pc_w;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       csr_w;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  op_code, mem_rdy,
    output mem_req, adr_s, alu_a_s, alu_b_s, alu_op, result_s,
           ir_w, pc_w, branch, reg_w, mem_w, csr_w, trap, trap_cause
  );

  modport slave (
    output op_code, mem_rdy,
    input  mem_req, adr_s, alu_a_s, alu_b_s, alu_op, result_s,
           ir_w, pc_w, branch, reg_w, mem_w, csr_w, trap, trap_cause
  );
endinterface

// File: rtl/main_fsm_mem_wdog.sv
// ---------------------------------------------------------------------------
// mem_wdog
// Memory-wait watchdog: a TW-bit up-counter, TW = $clog2(TIMEOUT+1).
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset (counter -> 0)
//   clr     in  clear counter (takes priority over count)
//   cnt_en  in  count one waiting cycle
//   expired out counter has reached TIMEOUT
// The counter stops at TIMEOUT so it can never wrap back to a quiet value.
// ---------------------------------------------------------------------------
module mem_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expired = (cnt_q == TW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en && !expired) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm
// Multicycle control FSM for the rv32i core. Steps each instruction through
// fetch / decode / execute / memory / writeback, drives the datapath selects
// and write enables, and traps on illegal opcodes or on a memory wait that
// outlasts TIMEOUT cycles.
// Parameters:
//   TIMEOUT  max cycles waiting on mem_rdy before trapping (1..65535)
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  synchronous active-low reset
//   bus      main_fsm_if.master: op_code/mem_rdy in; mem_req, adr_s,
//            alu_a_s, alu_b_s, alu_op, result_s, ir_w, pc_w, branch, reg_w,
//            mem_w, csr_w, trap, trap_cause out
// Optional feature macro: MAIN_FSM_CSR_EN -- opcode 115 runs the CSR state;
// otherwise it traps as illegal and csr_w stays 0.
// Outputs are Moore except ir_w/pc_w (FETCH) and mem_w (MEMWRITE), which
// follow mem_rdy so a write only fires on the completing cycle.
// ---------------------------------------------------------------------------
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  main_fsm_if.master bus
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] cause_q;
  logic [1:0] cause_d;

  logic       wait_state;
  logic       wdog_expired;
  logic       wdog_clr;
  logic       wdog_en;

  logic       mem_req;
  logic       adr_s;
  logic [1:0] alu_a_s;
  logic [1:0] alu_b_s;
  logic [1:0] alu_op;
  logic [1:0] result_s;
  logic       ir_w;
  logic       pc_w;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       csr_w;
  logic       trap;

  assign wait_state = is_mem_wait(state_q);
  assign wdog_en    = wait_state && !bus.mem_rdy;
  // Any state change restarts the wait budget for the next access.
  assign wdog_clr   = (state_d != state_q);

  mem_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wdog_clr),
    .cnt_en  (wdog_en),
    .expired (wdog_expired)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    mem_req  = 1'b0;
    adr_s    = ADR_PC;
    alu_a_s  = ALUA_PC;
    alu_b_s  = ALUB_RS2;
    alu_op   = ALUOP_ADD;
    result_s = RES_ALUOUT;
    ir_w     = 1'b0;
    pc_w     = 1'b0;
    branch   = 1'b0;
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    csr_w    = 1'b0;
    trap     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // PC + 4 is written straight from ALUResult while IR loads.
        mem_req  = 1'b1;
        adr_s    = ADR_PC;
        alu_a_s  = ALUA_PC;
        alu_b_s  = ALUB_FOUR;
        alu_op   = ALUOP_ADD;
        result_s = RES_ALURESULT;
        ir_w     = bus.mem_rdy;
        pc_w     = bus.mem_rdy;
        if (bus.mem_rdy) begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // oldPC + imm lands in ALUOut as the branch/jal target.
        alu_a_s = ALUA_OLDPC;
        alu_b_s = ALUB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = decode_op(bus.op_code);
        if (state_d == ST_TRAP) begin
          cause_d = CAUSE_ILLEGAL;
        end
      end

      ST_MEMADR: begin
        alu_a_s = ALUA_RS1;
        alu_b_s = ALUB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = (bus.op_code == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end

      ST_MEMREAD: begin
        mem_req = 1'b1;
        adr_s   = ADR_RESULT;
        if (bus.mem_rdy) begin
          state_d = ST_MEMWB;
        end
      end

      ST_MEMWB: begin
        result_s = RES_RDATA;
        reg_w    = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_MEMWRITE: begin
        mem_req = 1'b1;
        adr_s   = ADR_RESULT;
        mem_w   = bus.mem_rdy;
        if (bus.mem_rdy) begin
          state_d = ST_FETCH;
        end
      end

      ST_EXECR: begin
        alu_a_s = ALUA_RS1;
        alu_b_s = ALUB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end

      ST_EXECI: begin
        alu_b_s = ALUB_IMM;
        if (bus.op_code == OP_LUI) begin
          alu_a_s = ALUA_ZERO;
          alu_op  = ALUOP_ADD;
        end else if (bus.op_code == OP_AUIPC) begin
          alu_a_s = ALUA_OLDPC;
          alu_op  = ALUOP_ADD;
        end else begin
          alu_a_s = ALUA_RS1;
          alu_op  = ALUOP_FUNCT;
        end
        state_d = ST_ALUWB;
      end

      ST_ALUWB: begin
        result_s = RES_ALUOUT;
        reg_w    = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_BRANCH: begin
        // Target already in ALUOut from DECODE; the datapath qualifies pc_w.
        alu_a_s  = ALUA_RS1;
        alu_b_s  = ALUB_RS2;
        alu_op   = ALUOP_BRANCH;
        result_s = RES_ALUOUT;
        branch   = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_JALR: begin
        // Overwrites ALUOut with rs1 + imm, then shares the JAL path.
        alu_a_s = ALUA_RS1;
        alu_b_s = ALUB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = ST_JAL;
      end

      ST_JAL: begin
        // PC <- ALUOut (target) while the ALU forms the link oldPC + 4.
        alu_a_s  = ALUA_OLDPC;
        alu_b_s  = ALUB_FOUR;
        alu_op   = ALUOP_ADD;
        result_s = RES_ALUOUT;
        pc_w     = 1'b1;
        state_d  = ST_ALUWB;
      end

`ifdef MAIN_FSM_CSR_EN
      ST_CSR: begin
        result_s = RES_CSR;
        reg_w    = 1'b1;
        csr_w    = 1'b1;
        state_d  = ST_FETCH;
      end
`endif

      ST_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // A completing handshake in the same cycle beats the timeout.
    if (wait_state && !bus.mem_rdy && wdog_expired) begin
      state_d = ST_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end

    // Holding reset must not let any write or access escape.
    if (!rst_n) begin
      mem_req = 1'b0;
      ir_w    = 1'b0;
      pc_w    = 1'b0;
      branch  = 1'b0;
      reg_w   = 1'b0;
      mem_w   = 1'b0;
      csr_w   = 1'b0;
      trap    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.adr_s      = adr_s;
  assign bus.alu_a_s    = alu_a_s;
  assign bus.alu_b_s    = alu_b_s;
  assign bus.alu_op     = alu_op;
  assign bus.result_s   = result_s;
  assign bus.ir_w       = ir_w;
  assign bus.pc_w       = pc_w;
  assign bus.branch     = branch;
  assign bus.reg_w      = reg_w;
  assign bus.mem_w      = mem_w;
  assign bus.csr_w      = csr_w;
  assign bus.trap       = trap;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

  localparam int TB_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_fsm_if bus ();

  main_fsm #(
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       mem_req;
    logic       adr_s;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aluop;
    logic [1:0] res;
    logic       ir_w;
    logic       pc_w;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       csr_w;
    logic       trap;
    logic [1:0] cause;
  } out_t;

  typedef struct {
    logic rdy;
    out_t exp;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    int         wf;
    int         wm;
    int         cyc;
    logic [1:0] cause;
    string      name;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  cyc_t q[$];

  function automatic out_t sample();
    out_t o;
    o.mem_req = bus.mem_req;   o.adr_s  = bus.adr_s;
    o.a       = bus.alu_a_s;   o.b      = bus.alu_b_s;
    o.aluop   = bus.alu_op;    o.res    = bus.result_s;
    o.ir_w    = bus.ir_w;      o.pc_w   = bus.pc_w;
    o.branch  = bus.branch;    o.reg_w  = bus.reg_w;
    o.mem_w   = bus.mem_w;     o.csr_w  = bus.csr_w;
    o.trap    = bus.trap;      o.cause  = bus.trap_cause;
    return o;
  endfunction

  // Keep only the signals that reset must force low.
  function automatic out_t en_only(input out_t o);
    out_t r = '0;
    r.mem_req = o.mem_req; r.ir_w = o.ir_w; r.pc_w = o.pc_w;
    r.branch = o.branch; r.reg_w = o.reg_w; r.mem_w = o.mem_w;
    r.csr_w = o.csr_w; r.trap = o.trap;
    return r;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---- reference outputs, one per step of an instruction ----
  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.mem_req = 1; o.b = 2'b10; o.res = 2'b10; o.ir_w = rdy; o.pc_w = rdy;
    return o;
  endfunction
  function automatic out_t o_mem(input logic wr, input logic rdy);
    out_t o = '0;
    o.mem_req = 1; o.adr_s = 1; o.mem_w = wr & rdy;
    return o;
  endfunction
  function automatic out_t o_sel(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] aluop);
    out_t o = '0;
    o.a = a; o.b = b; o.aluop = aluop;
    return o;
  endfunction
  function automatic out_t o_wb(input logic [1:0] res);
    out_t o = '0;
    o.res = res; o.reg_w = 1;
    return o;
  endfunction
  function automatic out_t o_trap(input logic [1:0] cause);
    out_t o = '0;
    o.trap = 1; o.cause = cause;
    return o;
  endfunction

  // One memory access of w wait cycles; kind 0 fetch, 1 read, 2 write.
  // More than TB_TIMEOUT waits means the watchdog fires on wait TB_TIMEOUT+1.
  task automatic push_access(input int kind, input int w, output bit timed_out);
    int n;
    timed_out = (w > TB_TIMEOUT);
    n = timed_out ? TB_TIMEOUT + 1 : w;
    for (int k = 0; k < n; k++)
      q.push_back('{1'b0, (kind == 0) ? o_fetch(1'b0) : o_mem(kind == 2, 1'b0)});
    if (!timed_out)
      q.push_back('{1'b1, (kind == 0) ? o_fetch(1'b1) : o_mem(kind == 2, 1'b1)});
  endtask

  // Expected cycle-by-cycle trace of one instruction; returns the trap cause.
  task automatic build(input logic [6:0] op, input int wf, input int wm,
                       output logic [1:0] cause);
    bit to;
    cause = 2'b00;
    push_access(0, wf, to);
    if (to) cause = 2'b10;
    else begin
      q.push_back('{1'b0, o_sel(2'b01, 2'b01, 2'b00)});
      case (op)
        7'd3: begin
          q.push_back('{1'b0, o_sel(2'b10, 2'b01, 2'b00)});
          push_access(1, wm, to);
          if (to) cause = 2'b10; else q.push_back('{1'b0, o_wb(2'b01)});
        end
        7'd35: begin
          q.push_back('{1'b0, o_sel(2'b10, 2'b01, 2'b00)});
          push_access(2, wm, to);
          if (to) cause = 2'b10;
        end
        7'd51: begin
          q.push_back('{1'b0, o_sel(2'b10, 2'b00, 2'b10)});
          q.push_back('{1'b0, o_wb(2'b00)});
        end
        7'd19, 7'd55, 7'd23: begin
          if (op == 7'd19) q.push_back('{1'b0, o_sel(2'b10, 2'b01, 2'b10)});
          else if (op == 7'd55) q.push_back('{1'b0, o_sel(2'b11, 2'b01, 2'b00)});
          else q.push_back('{1'b0, o_sel(2'b01, 2'b01, 2'b00)});
          q.push_back('{1'b0, o_wb(2'b00)});
        end
        7'd99: begin
          out_t o = o_sel(2'b10, 2'b00, 2'b01);
          o.branch = 1;
          q.push_back('{1'b0, o});
        end
        7'd111, 7'd103: begin
          out_t o = o_sel(2'b01, 2'b10, 2'b00);
          o.pc_w = 1;
          if (op == 7'd103) q.push_back('{1'b0, o_sel(2'b10, 2'b01, 2'b00)});
          q.push_back('{1'b0, o});
          q.push_back('{1'b0, o_wb(2'b00)});
        end
`ifdef MAIN_FSM_CSR_EN
        7'd115: begin
          out_t o = o_wb(2'b11);
          o.csr_w = 1;
          q.push_back('{1'b0, o});
        end
`endif
        default: cause = 2'b01;
      endcase
    end
    if (cause != 2'b00) begin
      q.push_back('{1'($urandom_range(0, 1)), o_trap(cause)});
      q.push_back('{1'($urandom_range(0, 1)), o_trap(cause)});
    end
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    bus.mem_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    check(name, en_only(sample()), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Run one instruction against the model. exp_cyc > 0: drive exactly that
  // many cycles, then the DUT must be back in FETCH (or in TRAP).
  task automatic run(input logic [6:0] op, input int wf, input int wm,
                     input int exp_cyc, input logic [1:0] exp_cause,
                     input string name, output logic [1:0] cause);
    int n;
    q.delete();
    build(op, wf, wm, cause);
    bus.op_code = op;
    n = (exp_cyc > 0) ? exp_cyc : q.size();
    for (int i = 0; i < n; i++) begin
      bus.mem_rdy = (i < q.size()) ? q[i].rdy : 1'b0;
      @(negedge clk);
      if (i < q.size()) check($sformatf("%s_c%0d", name, i), sample(), q[i].exp);
      @(posedge clk); #1;
    end
    if (exp_cyc > 0) begin
      bus.mem_rdy = 1'b0;
      @(negedge clk);
      if (exp_cause == 2'b00) check({name, "_end"}, sample(), o_fetch(1'b0));
      else check({name, "_end"}, sample(), o_trap(exp_cause));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [1:0] c;
    logic [6:0] op;
    int wf, wm;
    logic [6:0] ops[10] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd55, 7'd23,
                            7'd99, 7'd111, 7'd103, 7'd115};

    vecs.push_back('{7'd51,  0, 0, 4, 2'b00, "rtype"});
    vecs.push_back('{7'd3,   0, 0, 5, 2'b00, "lw"});
    vecs.push_back('{7'd3,   0, 3, 8, 2'b00, "lw_wait3"});
    vecs.push_back('{7'd3,   0, 4, 9, 2'b00, "lw_wait_max"});
    vecs.push_back('{7'd35,  0, 0, 4, 2'b00, "sw"});
    vecs.push_back('{7'd35,  1, 2, 7, 2'b00, "sw_waits"});
    vecs.push_back('{7'd19,  0, 0, 4, 2'b00, "itype"});
    vecs.push_back('{7'd55,  0, 0, 4, 2'b00, "lui"});
    vecs.push_back('{7'd23,  2, 0, 6, 2'b00, "auipc_fw2"});
    vecs.push_back('{7'd99,  0, 0, 3, 2'b00, "branch"});
    vecs.push_back('{7'd111, 0, 0, 4, 2'b00, "jal"});
    vecs.push_back('{7'd103, 0, 0, 5, 2'b00, "jalr"});
    vecs.push_back('{7'd51,  4, 0, 8, 2'b00, "fetch_wait_max"});
`ifdef MAIN_FSM_CSR_EN
    vecs.push_back('{7'd115, 0, 0, 3, 2'b00, "csr"});
`else
    vecs.push_back('{7'd115, 0, 0, 2, 2'b01, "csr_illegal"});
`endif
    vecs.push_back('{7'h7F,  0, 0, 2, 2'b01, "illegal"});
    vecs.push_back('{7'd51,  5, 0, 5, 2'b10, "fetch_timeout"});
    vecs.push_back('{7'd3,   0, 5, 8, 2'b10, "read_timeout"});
    vecs.push_back('{7'd35,  0, 5, 8, 2'b10, "write_timeout"});

    bus.op_code = 7'd0;
    bus.mem_rdy = 1'b0;
    @(posedge clk); #1;
    do_reset("reset_hold");
    @(negedge clk);
    check("reset_state", sample(), o_fetch(1'b0));
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_reset({vecs[i].name, "_rst"});
      run(vecs[i].op, vecs[i].wf, vecs[i].wm, vecs[i].cyc, vecs[i].cause,
          vecs[i].name, c);
      @(posedge clk); #1;
    end

    // Trap is left only by reset; one reset edge returns to a clean FETCH.
    do_reset("illegal_rst");
    run(7'h7F, 0, 0, 2, 2'b01, "illegal2", c);
    @(posedge clk); #1;
    do_reset("trap_exit_rst");
    @(negedge clk);
    check("trap_exit_fetch", sample(), o_fetch(1'b0));
    @(posedge clk); #1;

    // Reset during JALR and during JAL: no pc_w/reg_w escapes.
    for (int k = 0; k < 2; k++) begin
      do_reset("midrst_pre");
      bus.op_code = (k == 0) ? 7'd103 : 7'd111;
      bus.mem_rdy = 1'b1;
      @(negedge clk); check("midrst_fetch", sample(), o_fetch(1'b1));
      @(posedge clk); #1;
      bus.mem_rdy = 1'b0;
      @(negedge clk); check("midrst_decode", sample(), o_sel(2'b01, 2'b01, 2'b00));
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk); check(k == 0 ? "rst_in_jalr" : "rst_in_jal", en_only(sample()), '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); check("midrst_back_fetch", sample(), o_fetch(1'b0));
      @(posedge clk); #1;
    end

    // Randomized back-to-back instruction stream.
    do_reset("rand_rst");
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                       : ops[$urandom_range(0, 9)];
      wf = ($urandom_range(0, 15) == 0) ? TB_TIMEOUT + 1 : $urandom_range(0, TB_TIMEOUT);
      wm = ($urandom_range(0, 15) == 0) ? TB_TIMEOUT + 1 : $urandom_range(0, TB_TIMEOUT);
      run(op, wf, wm, 0, 2'b00, $sformatf("rand%0d_op%0d", n, op), c);
      if (c != 2'b00) do_reset("rand_trap_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control FSM for the rv32i core; next generation of the single-cycle main decoder. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath mux selects, write enables and ALU mode, waits on a ready/request memory handshake, and guards every memory wait with a parametrised watchdog. Sits in `control_unit`, beside the ALU decoder, which still consumes `alu_op`.

## Interface
- `TIMEOUT`, 255: maximum cycles spent waiting on `mem_rdy` before trapping; legal range 1..65535.
- `TW`, $clog2(TIMEOUT+1): watchdog counter width (derived; do not override).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `op_code`  in  7  opcode field of the instruction register.
- `mem_rdy`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `adr_s`  out  1  address mux: 0 = PC, 1 = result.
- `alu_a_s`  out  2  ALU A: 00 PC, 01 oldPC, 10 rs1, 11 zero.
- `alu_b_s`  out  2  ALU B: 00 rs2, 01 imm, 10 const 4.
- `alu_op`  out  2  00 add, 01 branch compare, 10 funct-decoded.
- `result_s`  out  2  00 ALUOut, 01 read data, 10 ALUResult, 11 CSR data.
- `ir_w`, `pc_w`, `branch`, `reg_w`, `mem_w`, `csr_w`  out  1 each  enables.
- `trap`  out  1  high in TRAP.
- `trap_cause`  out  2  00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALR, JAL, CSR, TRAP.
- FETCH: `mem_req`=1, `adr_s`=0, `alu_a_s`=00, `alu_b_s`=10, `alu_op`=00, `result_s`=10. `ir_w` and `pc_w` equal `mem_rdy`. Stays in FETCH until `mem_rdy`, then goes to DECODE.
- DECODE: `alu_a_s`=01, `alu_b_s`=01, add, which computes the branch/jal target into ALUOut. Next state by opcode:
  - 3 and 35: MEMADR.
  - 51: EXECR.
  - 19, 55 (lui) and 23 (auipc): EXECI.
  - 99: BRANCH.
  - 111: JAL.
  - 103: JALR.
  - 115: CSR (macro-dependent).
  - Any other opcode: TRAP, with cause 01.
- MEMADR: A=rs1, B=imm, add. Next is MEMREAD for 3, MEMWRITE for 35.
- MEMREAD: `mem_req`=1, `adr_s`=1. Waits for `mem_rdy`, then MEMWB.
- MEMWB: `result_s`=01, `reg_w`=1. Next FETCH.
- MEMWRITE: `mem_req`=1, `adr_s`=1, `mem_w`=`mem_rdy`. Waits for `mem_rdy`, then FETCH.
- EXECR: A=rs1, B=rs2, `alu_op`=10. Next ALUWB.
- EXECI: B=imm. A=rs1 with `alu_op`=10 for op 19; A=zero (lui) or oldPC (auipc) with add. Next ALUWB.
- ALUWB: `result_s`=00, `reg_w`=1. Next FETCH.
- BRANCH: A=rs1, B=rs2, `alu_op`=01, `result_s`=00, `branch`=1. Next FETCH.
- JALR: A=rs1, B=imm, add. Next JAL.
- JAL: A=oldPC, B=4, add, `result_s`=00, `pc_w`=1. Next ALUWB.
- TRAP: terminal. `trap`=1; all enables and `mem_req` are 0. Only reset exits.
- Watchdog: counter cleared on every state change. It increments each cycle spent in FETCH, MEMREAD or MEMWRITE with `mem_rdy`=0. When it equals `TIMEOUT` with `mem_rdy` still 0, next state is TRAP with cause 10. `mem_rdy`=1 in the same cycle wins over the timeout.
- Unspecified selects are driven 0; there is no x on any output.

## Timing
- Moore outputs, except the `mem_rdy` gating of `ir_w`, `pc_w` and `mem_w`.
- Cycle counts with zero-wait memory: lw 5, sw 4, R/I/lui/auipc 4, branch 3, jal 4, jalr 5, csr 3.
- Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset:
  - While `rst_n`=0, all enables, `mem_req` and `trap` are forced to 0.
  - At the edge, state becomes FETCH, counter 0, `trap_cause` 00.
  - Reset mid-instruction abandons it with no writes.
- `trap_cause` is registered, set on entry to TRAP, and held until reset.

## Configuration
- `MAIN_FSM_CSR_EN` defined:
  - Opcode 115 goes to CSR.
  - CSR state: `result_s`=11, `reg_w`=1, `csr_w`=1. Next FETCH.
- `MAIN_FSM_CSR_EN` undefined:
  - CSR state is not compiled.
  - `csr_w` is tied to 0.
  - Opcode 115 traps with cause 01.

## Structure
- Package `main_fsm_pkg`: state enum, opcode constants (3, 35, 51, 99, 19, 55, 23, 111, 103, 115), select encodings, trap cause codes.
- Sub-module `mem_wdog`: `TW`-bit counter with clear, count-enable and `expired` output. Instanced once.

## Test plan
- R-type, `op_code`=51, `mem_rdy` held 1 → FETCH, DECODE, EXECR, ALUWB. `reg_w`=1 only in cycle 4, with `result_s`=00.
- lw with `mem_rdy` low for 3 cycles in MEMREAD → 8 cycles total. `reg_w` pulses once in MEMWB with `result_s`=01.
- `TIMEOUT`=4, `mem_rdy` stuck 0 in FETCH → TRAP after 5 FETCH cycles. `trap_cause`=10; `ir_w` never asserted.
- `op_code`=0x7F → TRAP after DECODE with `trap_cause`=01. `rst_n` low for one edge → FETCH, `trap`=0.
- `op_code`=115 → with macro, CSR state with `csr_w`=1 and 3-cycle latency; without macro, TRAP with cause 01.
- jalr followed by `rst_n`=0 asserted in the JALR state → no `pc_w` or `reg_w` pulse; FETCH on the next edge.
